// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: frame sequencer and two-source round-robin arbiter
// for the MiniLED driver RAM write port.
//
// Waits out the driver configuration window, then on every frame tick
// grants one pixel source, streams NUM_LED words into the driver RAM and
// pulses sdbpflag to latch the frame.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            allows frame ticks to start frames
//   req[1:0]          per-source frame request (level)
//   gnt[1:0]          one-hot grant, held for the whole frame
//   src_addr          pixel read address to the granted source
//   src_data0/1       source pixels, valid one cycle after src_addr
//   wten/wtaddr/wtdina driver RAM write port
//   sdbpflag          frame latch flag to the driver
//   cfg_done          configuration window elapsed (sticky)
//   busy              frame in progress
//   frame_done        one-cycle pulse at end of frame
//   overrun           sticky: a tick arrived while busy
module led_frame_scheduler #(
    parameter int NUM_LED      = 360,
    parameter int ADDR_W       = 10,
    parameter int CFG_WAIT     = 2500,
    parameter int FRAME_PERIOD = 420000,
    parameter int FLAG_LEN     = 29
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [15:0]       src_data0,
    input  logic [15:0]       src_data1,
    output logic              wten,
    output logic [ADDR_W-1:0] wtaddr,
    output logic [15:0]       wtdina,
    output logic              sdbpflag,
    output logic              cfg_done,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    localparam int PER_W  = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
    localparam int CFG_W  = (CFG_WAIT > 2) ? $clog2(CFG_WAIT) : 1;
    localparam int PH_MAX = (NUM_LED + 2 > FLAG_LEN) ? NUM_LED + 2 : FLAG_LEN;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(FRAME_PERIOD - 1);
    localparam logic [CFG_W-1:0]  CFG_LAST  = CFG_W'(CFG_WAIT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_LED - 1);
    // WRITE also covers the two-cycle read/register drain after the last read
    localparam logic [PH_W-1:0]   PH_WR_END = PH_W'(NUM_LED + 1);
    localparam logic [PH_W-1:0]   PH_FL_END = PH_W'(FLAG_LEN - 1);

    typedef enum logic [2:0] {
        S_CFG,
        S_IDLE,
        S_WRITE,
        S_FLAG,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CFG_W-1:0]  cfg_cnt_q;
    logic [PER_W-1:0]  per_q;
    logic [PH_W-1:0]   ph_q;
    logic              last_q;
    logic              iss_q;
    logic              v1_q;
    logic [ADDR_W-1:0] a1_q;
    logic [1:0]        gnt_q;
    logic [ADDR_W-1:0] src_addr_q;
    logic              wten_q;
    logic [ADDR_W-1:0] wtaddr_q;
    logic [15:0]       wtdina_q;
    logic              sdbpflag_q;
    logic              cfg_done_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              overrun_q;

    logic tick_d;
    logic win_d;

    assign tick_d = cfg_done_q && (per_q == '0);

    // 1 selects source 1; on contention the source not granted last wins
    always_comb begin
        win_d = req[1];
        if (req == 2'b11) begin
            win_d = ~last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CFG;
            cfg_cnt_q    <= '0;
            per_q        <= '0;
            ph_q         <= '0;
            last_q       <= 1'b1;
            iss_q        <= 1'b0;
            v1_q         <= 1'b0;
            a1_q         <= '0;
            gnt_q        <= '0;
            src_addr_q   <= '0;
            wten_q       <= 1'b0;
            wtaddr_q     <= '0;
            wtdina_q     <= '0;
            sdbpflag_q   <= 1'b0;
            cfg_done_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (!cfg_done_q || per_q == PER_LAST) begin
                per_q <= '0;
            end else begin
                per_q <= per_q + 1'b1;
            end

            if (tick_d && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
            end

            // read address -> source data -> registered write
            v1_q     <= iss_q;
            a1_q     <= src_addr_q;
            wten_q   <= v1_q;
            wtaddr_q <= v1_q ? a1_q : '0;
            wtdina_q <= v1_q ? (gnt_q[1] ? src_data1 : src_data0) : '0;

            frame_done_q <= 1'b0;

            case (state_q)
                S_CFG: begin
                    if (cfg_cnt_q == CFG_LAST) begin
                        cfg_done_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        cfg_cnt_q <= cfg_cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (tick_d && enable && req != 2'b00) begin
                        gnt_q      <= win_d ? 2'b10 : 2'b01;
                        last_q     <= win_d;
                        src_addr_q <= '0;
                        iss_q      <= 1'b1;
                        ph_q       <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    ph_q <= ph_q + 1'b1;
                    if (iss_q) begin
                        if (src_addr_q == ADDR_LAST) begin
                            iss_q      <= 1'b0;
                            src_addr_q <= '0;
                        end else begin
                            src_addr_q <= src_addr_q + 1'b1;
                        end
                    end
                    if (ph_q == PH_WR_END) begin
                        ph_q       <= '0;
                        sdbpflag_q <= 1'b1;
                        state_q    <= S_FLAG;
                    end
                end
                S_FLAG: begin
                    ph_q <= ph_q + 1'b1;
                    if (ph_q == PH_FL_END) begin
                        ph_q         <= '0;
                        sdbpflag_q   <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_CFG;
                end
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign src_addr   = src_addr_q;
    assign wten       = wten_q;
    assign wtaddr     = wtaddr_q;
    assign wtdina     = wtdina_q;
    assign sdbpflag   = sdbpflag_q;
    assign cfg_done   = cfg_done_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb_led_frame_scheduler: scoreboard bench for led_frame_scheduler.
// Instance A uses a legal frame period; instance B a too-short one.
module tb_led_frame_scheduler;

    localparam int N  = 8;
    localparam int FL = 4;

    typedef struct {
        int          cyc;
        logic [9:0]  addr;
        logic [15:0] data;
        logic [1:0]  gnt;
    } wr_t;

    typedef struct {
        int         cyc;
        logic [1:0] gnt;
    } done_t;

    logic clk;
    logic rst, rst_b;
    logic enable, enable_b;
    logic [1:0] req, req_b;

    logic [1:0]  gnt, gnt_b;
    logic [9:0]  src_addr, src_addr_b;
    logic [15:0] sd0, sd1, sd0_b, sd1_b;
    logic        wten, wten_b;
    logic [9:0]  wtaddr, wtaddr_b;
    logic [15:0] wtdina, wtdina_b;
    logic        sdbpflag, sdbpflag_b;
    logic        cfg_done, cfg_done_b;
    logic        busy, busy_b;
    logic        frame_done, frame_done_b;
    logic        overrun, overrun_b;

    int checks;
    int failures;
    int cyc_a;
    int cyc_b;
    int wb, fb, db;

    wr_t   qwa[$];
    int    qfa[$];
    done_t qda[$];
    wr_t   qb[$];

    led_frame_scheduler #(
        .NUM_LED(N), .ADDR_W(10), .CFG_WAIT(10),
        .FRAME_PERIOD(64), .FLAG_LEN(FL)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .gnt(gnt),
        .src_addr(src_addr), .src_data0(sd0), .src_data1(sd1),
        .wten(wten), .wtaddr(wtaddr), .wtdina(wtdina),
        .sdbpflag(sdbpflag), .cfg_done(cfg_done), .busy(busy),
        .frame_done(frame_done), .overrun(overrun)
    );

    led_frame_scheduler #(
        .NUM_LED(N), .ADDR_W(10), .CFG_WAIT(10),
        .FRAME_PERIOD(12), .FLAG_LEN(FL)
    ) dut_b (
        .clk(clk), .rst(rst_b), .enable(enable_b), .req(req_b), .gnt(gnt_b),
        .src_addr(src_addr_b), .src_data0(sd0_b), .src_data1(sd1_b),
        .wten(wten_b), .wtaddr(wtaddr_b), .wtdina(wtdina_b),
        .sdbpflag(sdbpflag_b), .cfg_done(cfg_done_b), .busy(busy_b),
        .frame_done(frame_done_b), .overrun(overrun_b)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // registered pixel sources: data follows address by one cycle
    always @(posedge clk) begin
        sd0   <= 16'h1100 + 16'(src_addr);
        sd1   <= 16'hA000 + 16'(src_addr);
        sd0_b <= 16'h1100 + 16'(src_addr_b);
        sd1_b <= 16'hA000 + 16'(src_addr_b);
    end

    // cycle 0 = cycle after the last edge that sampled rst high
    always @(posedge clk) begin
        cyc_a <= rst ? 0 : cyc_a + 1;
        cyc_b <= rst_b ? 0 : cyc_b + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push_a(input int t, input bit s);
        logic [1:0] g;
        g = s ? 2'b10 : 2'b01;
        for (int k = 0; k < N; k++) begin
            qwa.push_back('{t + 3 + k, 10'(k),
                           (s ? 16'hA000 : 16'h1100) + 16'(k), g});
        end
        for (int j = 0; j < FL; j++) begin
            qfa.push_back(t + 3 + N + j);
        end
        qda.push_back('{t + 3 + N + FL, g});
    endtask

    task automatic at_cyc(input int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc_a != c && n < 5000);
        if (cyc_a != c) chk("wait_cyc", 64'(cyc_a), 64'(c));
    endtask

    // monitor A: every write, flag cycle and frame_done against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (wten) begin
                if (qwa.size() == 0) begin
                    chk("a_wr_unexpected", 64'(wten), 64'd0);
                end else begin
                    wr_t w;
                    w = qwa.pop_front();
                    chk("a_wr_cyc", 64'(cyc_a), 64'(w.cyc));
                    chk("a_wr_addr", 64'(wtaddr), 64'(w.addr));
                    chk("a_wr_data", 64'(wtdina), 64'(w.data));
                    chk("a_wr_gnt", 64'(gnt), 64'(w.gnt));
                end
            end else begin
                chk("a_wr_idle_zero", 64'({wtaddr, wtdina}), 64'd0);
            end
            if (sdbpflag) begin
                if (qfa.size() == 0) chk("a_flag_unexpected", 64'(sdbpflag), 64'd0);
                else chk("a_flag_cyc", 64'(cyc_a), 64'(qfa.pop_front()));
            end
            if (frame_done) begin
                if (qda.size() == 0) begin
                    chk("a_done_unexpected", 64'(frame_done), 64'd0);
                end else begin
                    done_t d;
                    d = qda.pop_front();
                    chk("a_done_cyc", 64'(cyc_a), 64'(d.cyc));
                    chk("a_done_gnt", 64'(gnt), 64'(d.gnt));
                end
            end
        end
    end

    // monitor B
    always @(negedge clk) begin
        if (!rst_b) begin
            if (wten_b) begin
                wb++;
                if (qb.size() == 0) begin
                    chk("b_wr_unexpected", 64'(wten_b), 64'd0);
                end else begin
                    wr_t w;
                    w = qb.pop_front();
                    chk("b_wr_cyc", 64'(cyc_b), 64'(w.cyc));
                    chk("b_wr_addr", 64'(wtaddr_b), 64'(w.addr));
                    chk("b_wr_data", 64'(wtdina_b), 64'(w.data));
                end
            end
            if (sdbpflag_b) fb++;
            if (frame_done_b) db++;
        end
    end

    initial begin
        checks = 0; failures = 0; wb = 0; fb = 0; db = 0;
        cyc_a = 0; cyc_b = 0;
        rst = 1'b1; rst_b = 1'b1;
        enable = 1'b1; enable_b = 1'b1;
        req = 2'b01; req_b = 2'b01;

        // startup frame on both instances, tick at cycle 10
        push_a(10, 1'b0);
        for (int k = 0; k < N; k++) begin
            qb.push_back('{13 + k, 10'(k), 16'h1100 + 16'(k), 2'b01});
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({gnt, src_addr, wten, wtaddr, wtdina,
            sdbpflag, cfg_done, busy, frame_done, overrun}), 64'd0);
        rst = 1'b0; rst_b = 1'b0;

        at_cyc(9);
        chk("cfg_done_c9", 64'(cfg_done), 64'd0);
        at_cyc(10);
        chk("cfg_done_c10", 64'(cfg_done), 64'd1);
        at_cyc(11);
        chk("gnt_busy_c11", 64'({gnt, busy, src_addr}), 64'({2'b01, 1'b1, 10'd0}));
        req_b = 2'b00;

        // B: tick at 22 lands in FLAG and is dropped
        at_cyc(22);
        chk("b_overrun_pre", 64'(overrun_b), 64'd0);
        at_cyc(24);
        chk("b_overrun_post", 64'(overrun_b), 64'd1);

        // idle conditions: no request, then enable low
        at_cyc(26);
        chk("a_idle_after_frame", 64'({gnt, busy}), 64'd0);
        req = 2'b00;
        at_cyc(75);
        chk("a_noreq_tick", 64'({gnt, busy, sdbpflag}), 64'd0);
        at_cyc(80);
        enable = 1'b0;
        req = 2'b01;
        at_cyc(100);
        chk("b_writes", 64'(wb), 64'(N));
        chk("b_flags", 64'(fb), 64'(FL));
        chk("b_dones", 64'(db), 64'd1);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        at_cyc(139);
        chk("a_disabled_tick", 64'({gnt, busy, sdbpflag}), 64'd0);

        // request dropped mid-frame
        at_cyc(150);
        enable = 1'b1;
        push_a(202, 1'b0);
        at_cyc(207);
        chk("a_drop_point", 64'({wten, wtaddr}), 64'({1'b1, 10'd2}));
        req = 2'b00;

        // reset in the middle of a frame
        at_cyc(230);
        req = 2'b01;
        push_a(266, 1'b0);
        at_cyc(273);
        chk("a_rst_point", 64'({wten, wtaddr}), 64'({1'b1, 10'd4}));
        rst = 1'b1;
        @(posedge clk);
        #1;
        qwa.delete();
        qfa.delete();
        qda.delete();
        @(negedge clk);
        chk("rst_mid_outputs", 64'({gnt, src_addr, wten, wtaddr, wtdina,
            sdbpflag, cfg_done, busy, frame_done, overrun}), 64'd0);
        rst = 1'b0;

        // round-robin from a fresh pointer
        req = 2'b11;
        push_a(10, 1'b0);
        push_a(74, 1'b1);
        push_a(138, 1'b0);
        at_cyc(9);
        chk("cfg_done_rst_c9", 64'(cfg_done), 64'd0);
        at_cyc(10);
        chk("cfg_done_rst_c10", 64'(cfg_done), 64'd1);
        at_cyc(11);
        chk("rr_gnt_1", 64'(gnt), 64'(2'b01));
        at_cyc(75);
        chk("rr_gnt_2", 64'(gnt), 64'(2'b10));
        at_cyc(139);
        chk("rr_gnt_3", 64'(gnt), 64'(2'b01));
        at_cyc(150);
        req = 2'b00;
        at_cyc(210);
        chk("a_wr_queue_empty", 64'(qwa.size()), 64'd0);
        chk("a_flag_queue_empty", 64'(qfa.size()), 64'd0);
        chk("a_done_queue_empty", 64'(qda.size()), 64'd0);
        chk("a_no_overrun", 64'(overrun), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
